iob_bfifo_gen: RTL

//  Bit-granular FIFO with independent write/read data widths and depth. Each cycle it accepts 0..WDATA_W bits and delivers 0..RDATA_W bits.

---
 rtl/iob_bfifo_gen_pkg.sv | 14 +
 rtl/iob_bfifo_gen_shift.sv | 35 +++
 rtl/iob_bfifo_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/iob_bfifo_gen_pkg.sv
// rtl/iob_bfifo_gen_pkg.sv - shared types and helpers for the bit-granular FIFO
package iob_bfifo_gen_pkg;

    // Rotation direction of the shift/mask helper
    typedef enum logic {
        ROT_RIGHT = 1'b0,
        ROT_LEFT  = 1'b1
    } rot_dir_e;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/iob_bfifo_gen_shift.sv
// rtl/iob_bfifo_gen_shift.sv - circular rotate plus MSB-aligned mask generator
module iob_bfifo_gen_shift
    import iob_bfifo_gen_pkg::*;
#(
    parameter int       W        = 64,
    parameter int       OUT_W    = 64,
    parameter int       LEN_W    = 7,
    parameter rot_dir_e DIR      = ROT_RIGHT,
    parameter bit       ROT_MASK = 1'b1
) (
    input  logic [W-1:0]         din_i,
    input  logic [$clog2(W)-1:0] shamt_i,
    input  logic [LEN_W-1:0]     len_i,
    output logic [OUT_W-1:0]     rot_o,
    output logic [OUT_W-1:0]     mask_o
);

    localparam int SH_W = $clog2(W);

    logic [SH_W-1:0] rshamt;
    logic [W-1:0]    rot_full;
    logic [W-1:0]    top_mask;
    logic [W-1:0]    mask_full;

    // A left rotation by s is a right rotation by W-s (mod W)
    assign rshamt    = (DIR == ROT_LEFT) ? SH_W'(~shamt_i + 1'b1) : shamt_i;
    assign rot_full  = W'({din_i, din_i} >> rshamt);
    // Ones in the top len_i bits; len_i == W gives all ones
    assign top_mask  = ~({W{1'b1}} >> len_i);
    assign mask_full = ROT_MASK ? W'({top_mask, top_mask} >> rshamt) : top_mask;

    assign rot_o  = OUT_W'(rot_full >> (W - OUT_W));
    assign mask_o = OUT_W'(mask_full >> (W - OUT_W));

endmodule

// File: rtl/iob_bfifo_gen.sv
// rtl/iob_bfifo_gen.sv - bit-granular FIFO, optional IOB_BFIFO_GEN_ERR_EN error flags
module iob_bfifo_gen
    import iob_bfifo_gen_pkg::*;
#(
    parameter int WDATA_W  = 16,
    parameter int RDATA_W  = 8,
    parameter int BUF_SIZE = 64
) (
    input  logic                          clk_i,
    input  logic                          cke_i,
    input  logic                          arst_n_i,
    input  logic                          rst_i,
    input  logic                          write_i,
    input  logic [$clog2(WDATA_W):0]      wwidth_i,
    input  logic [WDATA_W-1:0]            wdata_i,
    output logic                          wack_o,
    output logic [$clog2(BUF_SIZE):0]     wlevel_o,
    input  logic                          read_i,
    input  logic [$clog2(RDATA_W):0]      rwidth_i,
    output logic [RDATA_W-1:0]            rdata_o,
    output logic                          rack_o,
    output logic [$clog2(BUF_SIZE):0]     rlevel_o
`ifdef IOB_BFIFO_GEN_ERR_EN
    ,
    output logic                          overflow_o,
    output logic                          underflow_o
`endif
);

    localparam int PTR_W = $clog2(BUF_SIZE);
    localparam int LVL_W = PTR_W + 1;
    localparam int WW_W  = $clog2(WDATA_W) + 1;
    localparam int RW_W  = $clog2(RDATA_W) + 1;

    // Bit at pointer position p lives in data[BUF_SIZE-1-p], so the stream is MSB-first
    logic [BUF_SIZE-1:0] data;
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [LVL_W-1:0]    level;

    logic [BUF_SIZE-1:0] wvec;
    logic [BUF_SIZE-1:0] wrot;
    logic [BUF_SIZE-1:0] wmask;
    logic [BUF_SIZE-1:0] data_nxt;
    logic [LVL_W-1:0]    level_nxt;
    logic [LVL_W-1:0]    rd_len;
    logic [RDATA_W-1:0]  rrot;
    logic [RDATA_W-1:0]  rmask;

    assign wlevel_o = LVL_W'(BUF_SIZE) - level;
    assign rlevel_o = level;

    assign wack_o = cke_i & write_i & (32'(wwidth_i) <= WDATA_W) & (32'(wwidth_i) <= 32'(wlevel_o));
    assign rack_o = cke_i & read_i & (32'(rwidth_i) <= RDATA_W) & (32'(rwidth_i) <= 32'(level));

    // Write path: left-align wdata in a buffer-wide word, rotate it to wptr
    assign wvec = BUF_SIZE'(wdata_i) << (BUF_SIZE - WDATA_W);

    iob_bfifo_gen_shift #(
        .W        (BUF_SIZE),
        .OUT_W    (BUF_SIZE),
        .LEN_W    (WW_W),
        .DIR      (ROT_RIGHT),
        .ROT_MASK (1'b1)
    ) u_wshift (
        .din_i   (wvec),
        .shamt_i (wptr),
        .len_i   (wwidth_i),
        .rot_o   (wrot),
        .mask_o  (wmask)
    );

    assign data_nxt = (data & ~wmask) | (wrot & wmask);

    // Read path: bring rptr to the top, keep only min(rwidth, level) bits
    assign rd_len = LVL_W'(min_u(32'(rwidth_i), 32'(level)));

    iob_bfifo_gen_shift #(
        .W        (BUF_SIZE),
        .OUT_W    (RDATA_W),
        .LEN_W    (LVL_W),
        .DIR      (ROT_LEFT),
        .ROT_MASK (1'b0)
    ) u_rshift (
        .din_i   (data),
        .shamt_i (rptr),
        .len_i   (rd_len),
        .rot_o   (rrot),
        .mask_o  (rmask)
    );

    assign rdata_o = rrot & rmask;

    // Level is bounded by the accept checks, so the sum never leaves [0, BUF_SIZE]
    assign level_nxt = level
                     + (wack_o ? LVL_W'(wwidth_i) : LVL_W'(0))
                     - (rack_o ? LVL_W'(rwidth_i) : LVL_W'(0));

    // Storage and pointer registers; cke_i gates everything including the sync reset
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data  <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                data  <= '0;
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (wack_o) begin
                    data <= data_nxt;
                    wptr <= wptr + PTR_W'(wwidth_i);
                end
                if (rack_o) begin
                    rptr <= rptr + PTR_W'(rwidth_i);
                end
                level <= level_nxt;
            end
        end
    end

`ifdef IOB_BFIFO_GEN_ERR_EN
    // Sticky flags for rejected requests, visible the cycle after the event
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                overflow_o  <= 1'b0;
                underflow_o <= 1'b0;
            end else begin
                if (write_i && !wack_o) overflow_o  <= 1'b1;
                if (read_i && !rack_o)  underflow_o <= 1'b1;
            end
        end
    end
`endif

endmodule
